// File: rtl/rv32_fetch_pkg.sv
// Shared fetch-stage definitions: data width, NOP encoding, reset PC,
// fetch-control state encodings and the queued {pc, instr} entry type.
package rv32_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int BUF_DEPTH_DEFAULT = 2;

   typedef enum logic [1:0] {
      FETCH    = 2'b00,
      WAIT_MEM = 2'b01,
      FULL     = 2'b10
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {pc, instr} pairs with flush.
// Ports: clk, rst (async high), push/push_pc/push_instr, pop, flush,
//        head_pc/head_instr (oldest entry), count, full, empty.
module fetch_buffer
   import rv32_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_instr,
   input  logic            pop,
   input  logic            flush,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_instr,
   output logic [CW-1:0]   count,
   output logic            full,
   output logic            empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   mem_d [DEPTH];
   logic [PW-1:0]  rd_q, rd_d;
   logic [PW-1:0]  wr_q, wr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           wr_en;
   logic           rd_en;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign count = cnt_q;
   assign head_pc    = mem_q[rd_q].pc;
   assign head_instr = mem_q[rd_q].instr;

   // Writes into a full queue are dropped rather than corrupting the head.
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (wr_en) begin
            mem_d[wr_q] = '{pc: push_pc, instr: push_instr};
            wr_d = bump(wr_q);
         end
         if (rd_en) begin
            rd_d = bump(rd_q);
         end
         case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem address, in-flight tag and credit-based
// issue; fetched words queue in fetch_buffer and drive the IF/ID outputs.
// Ports: CLK, RESET (async high); IMEM_ADDRESS/IMEM_READ_DATA/IMEM_BUSYWAIT;
//        BRANCH_TAKEN/BRANCH_TARGET; STALL; IF_ID_VALID/INSTRUCTION/PC/PC_PLUS4.
module instruction_fetch_unit
   import rv32_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [31:0] IMEM_ADDRESS,
   input  logic [31:0] IMEM_READ_DATA,
   input  logic        IMEM_BUSYWAIT,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   input  logic        STALL,
   output logic        IF_ID_VALID,
   output logic [31:0] IF_ID_INSTRUCTION,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_PC_PLUS4
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tag_q, tag_d;
   logic         inflight_q, inflight_d;
   fetch_state_e state_q, state_d;

   logic [CW-1:0] buf_count;
   logic          buf_full;
   logic          buf_empty;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;
   logic [CW:0]   used;
   logic          credit;
   logic          issue;
   logic          push;
   logic          pop;

   // A slot is reserved for the in-flight word, so a push never meets a full queue.
   assign used   = {1'b0, buf_count} + {{CW{1'b0}}, inflight_q};
   assign credit = !buf_full && (used < (CW + 1)'(BUF_DEPTH));

   assign IMEM_ADDRESS = word_align(pc_q);

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (CLK),
      .rst        (RESET),
      .push       (push),
      .push_pc    (tag_q),
      .push_instr (IMEM_READ_DATA),
      .pop        (pop),
      .flush      (BRANCH_TAKEN),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (buf_count),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   assign IF_ID_VALID       = !buf_empty;
   assign IF_ID_INSTRUCTION = buf_empty ? NOP_INSTR : head_instr;
   assign IF_ID_PC          = buf_empty ? 32'h0 : head_pc;
   assign IF_ID_PC_PLUS4    = buf_empty ? 32'h0 : head_pc + 32'd4;

   // Issue control: the state mirrors why fetch is or is not issuing.
   always_comb begin
      state_d = state_q;
      issue   = !IMEM_BUSYWAIT && !BRANCH_TAKEN && credit;
      push    = inflight_q && !IMEM_BUSYWAIT && !BRANCH_TAKEN;
      pop     = IF_ID_VALID && !STALL && !BRANCH_TAKEN;
      case (state_q)
         FETCH: begin
            if (IMEM_BUSYWAIT) begin
               state_d = WAIT_MEM;
            end else if (!credit) begin
               state_d = FULL;
            end
         end
         WAIT_MEM: begin
            if (!IMEM_BUSYWAIT) begin
               state_d = FETCH;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      if (BRANCH_TAKEN) begin
         state_d = FETCH;
      end
   end

   always_comb begin
      pc_d       = pc_q;
      tag_d      = tag_q;
      inflight_d = inflight_q;
      if (BRANCH_TAKEN) begin
         pc_d       = word_align(BRANCH_TARGET);
         inflight_d = 1'b0;
      end else if (IMEM_BUSYWAIT) begin
         inflight_d = inflight_q;
      end else if (issue) begin
         pc_d       = pc_q + 32'd4;
         tag_d      = pc_q;
         inflight_d = 1'b1;
      end else begin
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc_q       <= RESET_PC;
         tag_q      <= RESET_PC;
         inflight_q <= 1'b0;
         state_q    <= FETCH;
      end else begin
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
      end
   end

   a_no_full_push : assert property (
      @(posedge CLK) disable iff (RESET) !(push && buf_full)
   );

endmodule
